// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM encoding, operand
// forward select codes, scoreboard entry layout and lookup helpers.
package pipe_ctrl_pkg;

  localparam int unsigned REG_W = 5;
  localparam int unsigned FWD_W = 2;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERR      = 2'd2
  } state_e;

  localparam logic [FWD_W-1:0] FWD_REG   = 2'b00;
  localparam logic [FWD_W-1:0] FWD_EXMEM = 2'b10;
  localparam logic [FWD_W-1:0] FWD_MEMWB = 2'b01;

  // One in-flight instruction as seen by the hazard logic.
  typedef struct packed {
    logic             v;        // writes a non-zero register
    logic [REG_W-1:0] rd;
    logic             memread;  // load
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;       // zero when rt is not read
  } sb_entry_t;

  // True when entry e produces register src; rd==0 never sets v, so $0 never matches.
  function automatic logic reg_match(input logic [REG_W-1:0] src, input sb_entry_t e);
    return e.v && (e.rd == src);
  endfunction

  // Forward select for one EX operand: the younger producer (EX_MEM) wins.
  function automatic logic [FWD_W-1:0] fwd_sel(input logic [REG_W-1:0] src,
                                                input sb_entry_t mem_e,
                                                input sb_entry_t wb_e);
    if (reg_match(src, mem_e))     return FWD_EXMEM;
    else if (reg_match(src, wb_e)) return FWD_MEMWB;
    else                           return FWD_REG;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle between the pipeline datapath and the hazard controller.
// master: datapath (drives ID/EX/MEM status, receives controls)
// slave : pipe_hazard_ctrl
interface pipe_hazard_ctrl_if #(parameter int unsigned CNT_W = 16);
  import pipe_ctrl_pkg::*;

  logic             id_valid;
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_uses_rt;
  logic [REG_W-1:0] id_rd;
  logic             id_regwrite;
  logic             id_memread;
  logic             ex_br_taken;
  logic             mem_access;
  logic             dmem_ack;

  logic             pc_we;
  logic             ifid_we;
  logic             ifid_flush;
  logic             idex_bubble;
  logic             pipe_we;
  logic             dmem_req;
  logic [FWD_W-1:0] fwd_a;
  logic [FWD_W-1:0] fwd_b;
  logic [CNT_W-1:0] stall_cnt;
  logic             err_timeout;

  modport master (
    output id_valid, id_rs, id_rt, id_uses_rt, id_rd, id_regwrite, id_memread,
           ex_br_taken, mem_access, dmem_ack,
    input  pc_we, ifid_we, ifid_flush, idex_bubble, pipe_we, dmem_req,
           fwd_a, fwd_b, stall_cnt, err_timeout
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_uses_rt, id_rd, id_regwrite, id_memread,
           ex_br_taken, mem_access, dmem_ack,
    output pc_we, ifid_we, ifid_flush, idex_bubble, pipe_we, dmem_req,
           fwd_a, fwd_b, stall_cnt, err_timeout
  );

endinterface

// File: rtl/pipe_scoreboard.sv
// Shadow copy of the EX/MEM/WB destination registers plus RAW comparators.
// Ports: CLK, RSTn; i_shift (pipe advances), i_bubble (EX loads NOP);
//        i_id_* (decoded ID instruction); o_hazard (ID must stall);
//        o_fwd_a/o_fwd_b (operand selects for the EX instruction).
// Optional feature: PIPE_FWD_EN (forwarding, load-use-only stalls).
module pipe_scoreboard
  import pipe_ctrl_pkg::*;
(
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             i_shift,
  input  logic             i_bubble,
  input  logic             i_id_valid,
  input  logic [REG_W-1:0] i_id_rs,
  input  logic [REG_W-1:0] i_id_rt,
  input  logic             i_id_uses_rt,
  input  logic [REG_W-1:0] i_id_rd,
  input  logic             i_id_regwrite,
  input  logic             i_id_memread,
  output logic             o_hazard,
  output logic [FWD_W-1:0] o_fwd_a,
  output logic [FWD_W-1:0] o_fwd_b
);

  sb_entry_t        r_ex, r_mem, r_wb;
  sb_entry_t        w_new;
  logic [REG_W-1:0] w_rt_used;
  logic             w_hit;
  logic             w_unused;

  // Entry the ID instruction becomes in EX; a bubble or empty slot is all-zero.
  always_comb begin
    w_new = '0;
    if (!i_bubble && i_id_valid) begin
      w_new.v       = i_id_regwrite && (i_id_rd != '0);
      w_new.rd      = i_id_rd;
      w_new.memread = i_id_memread;
      w_new.rs      = i_id_rs;
      w_new.rt      = i_id_uses_rt ? i_id_rt : '0;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_ex  <= '0;
      r_mem <= '0;
      r_wb  <= '0;
    end else if (i_shift) begin
      r_wb  <= r_mem;
      r_mem <= r_ex;
      r_ex  <= w_new;
    end
  end

  // RAW detection; the register file is write-first, so WB is never checked.
  always_comb begin
    w_rt_used = i_id_uses_rt ? i_id_rt : '0;
`ifdef PIPE_FWD_EN
    w_hit = r_ex.memread && (reg_match(i_id_rs, r_ex) || reg_match(w_rt_used, r_ex));
`else
    w_hit = reg_match(i_id_rs, r_ex)   || reg_match(w_rt_used, r_ex) ||
            reg_match(i_id_rs, r_mem)  || reg_match(w_rt_used, r_mem);
`endif
    o_hazard = i_id_valid && w_hit;
  end

`ifdef PIPE_FWD_EN
  assign o_fwd_a = fwd_sel(r_ex.rs, r_mem, r_wb);
  assign o_fwd_b = fwd_sel(r_ex.rt, r_mem, r_wb);
`else
  assign o_fwd_a = FWD_REG;
  assign o_fwd_b = FWD_REG;
`endif

  // Fields not read in every build are folded here.
  assign w_unused = ^{r_ex, r_mem, r_wb};

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and stall sequencer for the 5-stage MIPS pipeline.
// Ports: CLK (rising edge), RSTn (async, active-low),
//        bus (pipe_hazard_ctrl_if.slave): ID/EX/MEM status in; PC/stage
//        enables, flush/bubble, DMem request, forward selects, stall_cnt
//        and sticky err_timeout out.
// Parameters: MEM_TIMEOUT (max DMem wait cycles), CNT_W (stall_cnt width).
// Optional feature: PIPE_FWD_EN (forwarding; only load-use stalls).
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 16
) (
  input logic              CLK,
  input logic              RSTn,
  pipe_hazard_ctrl_if.slave bus
);

  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

  state_e            r_state, w_state_nxt;
  logic [WAIT_W-1:0] r_wait, w_wait_nxt;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic              w_hazard, w_freeze;
  logic              w_pc_we, w_ifid_we, w_ifid_flush, w_idex_bubble, w_pipe_we, w_dmem_req;
  logic [FWD_W-1:0]  w_fwd_a, w_fwd_b;

  pipe_scoreboard u_sb (
    .CLK           (CLK),
    .RSTn          (RSTn),
    .i_shift       (w_pipe_we),
    .i_bubble      (w_idex_bubble),
    .i_id_valid    (bus.id_valid),
    .i_id_rs       (bus.id_rs),
    .i_id_rt       (bus.id_rt),
    .i_id_uses_rt  (bus.id_uses_rt),
    .i_id_rd       (bus.id_rd),
    .i_id_regwrite (bus.id_regwrite),
    .i_id_memread  (bus.id_memread),
    .o_hazard      (w_hazard),
    .o_fwd_a       (w_fwd_a),
    .o_fwd_b       (w_fwd_b)
  );

  // State register, wait counter and saturating stall counter.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_state     <= ST_RUN;
      r_wait      <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_wait  <= w_wait_nxt;
      if (!w_pc_we && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  // Next state and controls; priority is freeze > branch > hazard.
  // Controls are held at their run defaults while RSTn is low.
  always_comb begin
    w_state_nxt   = r_state;
    w_wait_nxt    = r_wait;
    w_freeze      = 1'b0;
    w_pc_we       = 1'b1;
    w_ifid_we     = 1'b1;
    w_ifid_flush  = 1'b0;
    w_idex_bubble = 1'b0;
    w_pipe_we     = 1'b1;
    w_dmem_req    = 1'b0;
    if (RSTn) begin
      unique case (r_state)
        ST_RUN: begin
          w_dmem_req = bus.mem_access;
          w_wait_nxt = '0;
          if (bus.mem_access && !bus.dmem_ack) begin
            w_freeze    = 1'b1;
            w_state_nxt = ST_MEM_WAIT;
          end
        end
        ST_MEM_WAIT: begin
          w_dmem_req = 1'b1;
          if (bus.dmem_ack) begin
            w_state_nxt = ST_RUN;
            w_wait_nxt  = '0;
          end else begin
            w_freeze   = 1'b1;
            w_wait_nxt = r_wait + WAIT_W'(1);
            if (w_wait_nxt == WAIT_W'(MEM_TIMEOUT))
              w_state_nxt = ST_ERR;
          end
        end
        ST_ERR: w_freeze = 1'b1;
        default: w_state_nxt = ST_RUN;
      endcase

      if (w_freeze) begin
        w_pc_we   = 1'b0;
        w_ifid_we = 1'b0;
        w_pipe_we = 1'b0;
      end else if (bus.ex_br_taken) begin
        // Redirect: the ID instruction is dropped, so any stall it wanted is moot.
        w_ifid_flush  = 1'b1;
        w_idex_bubble = 1'b1;
      end else if (w_hazard) begin
        w_pc_we       = 1'b0;
        w_ifid_we     = 1'b0;
        w_idex_bubble = 1'b1;
      end
    end
  end

  assign bus.pc_we       = w_pc_we;
  assign bus.ifid_we     = w_ifid_we;
  assign bus.ifid_flush  = w_ifid_flush;
  assign bus.idex_bubble = w_idex_bubble;
  assign bus.pipe_we     = w_pipe_we;
  assign bus.dmem_req    = w_dmem_req;
  assign bus.fwd_a       = w_fwd_a;
  assign bus.fwd_b       = w_fwd_b;
  assign bus.stall_cnt   = r_stall_cnt;
  assign bus.err_timeout = (r_state == ST_ERR);

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl; expectations follow PIPE_FWD_EN.
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.CNT_W(16)) bus ();

  pipe_hazard_ctrl #(.MEM_TIMEOUT(15), .CNT_W(16)) u_dut (
    .CLK  (clk),
    .RSTn (rst_n),
    .bus  (bus)
  );

  // {pc_we, ifid_we, ifid_flush, idex_bubble, pipe_we, dmem_req}
  logic [5:0] ctl;
  assign ctl = {bus.pc_we, bus.ifid_we, bus.ifid_flush, bus.idex_bubble, bus.pipe_we, bus.dmem_req};

  localparam logic [5:0] NORM   = 6'b110010;
  localparam logic [5:0] STALL  = 6'b000110;
  localparam logic [5:0] BRANCH = 6'b111110;
  localparam logic [5:0] FREEZE = 6'b000001;
  localparam logic [5:0] DEAD   = 6'b000000;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic urt, input logic [4:0] rd, input logic rw, input logic mr);
    bus.id_valid = v; bus.id_rs = rs; bus.id_rt = rt; bus.id_uses_rt = urt;
    bus.id_rd = rd; bus.id_regwrite = rw; bus.id_memread = mr;
  endtask

  task automatic idle_in();
    set_id(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    bus.ex_br_taken = 1'b0; bus.mem_access = 1'b0; bus.dmem_ack = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Check the combinational controls mid-cycle, then advance one clock.
  task automatic step_ctl(input string tag, input logic [5:0] exp);
    @(negedge clk);
    check(tag, 32'(ctl), 32'(exp));
    tick();
  endtask

  task automatic do_reset();
    idle_in();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1;
    idle_in();
    tick();

    // Reset state, with a pending memory access that must not request.
    rst_n = 1'b0;
    bus.mem_access = 1'b1;
    #1;
    check("rst_ctl", 32'(ctl), 32'(NORM));
    check("rst_fwd", 32'({bus.fwd_a, bus.fwd_b}), 32'h0);
    check("rst_cnt", 32'(bus.stall_cnt), 32'h0);
    check("rst_err", 32'(bus.err_timeout), 32'h0);
    do_reset();

    // 1: add $3,$1,$2 ; sub $4,$3,$5
    set_id(1, 5'd1, 5'd2, 1, 5'd3, 1, 0);
    step_ctl("t1_add", NORM);
    set_id(1, 5'd3, 5'd5, 1, 5'd4, 1, 0);
`ifdef PIPE_FWD_EN
    step_ctl("t1_sub_go", NORM);
    idle_in();
    @(negedge clk);
    check("t1_fwd_a", 32'(bus.fwd_a), 32'h2);
    check("t1_fwd_b", 32'(bus.fwd_b), 32'h0);
    tick();
    check("t1_cnt", 32'(bus.stall_cnt), 32'd0);
`else
    step_ctl("t1_stall1", STALL);
    step_ctl("t1_stall2", STALL);
    step_ctl("t1_sub_go", NORM);
    idle_in();
    @(negedge clk);
    check("t1_fwd", 32'({bus.fwd_a, bus.fwd_b}), 32'h0);
    tick();
    check("t1_cnt", 32'(bus.stall_cnt), 32'd2);
`endif

    // 2: lw $3,0($1) ; add $4,$3,$3
    do_reset();
    set_id(1, 5'd1, 5'd3, 0, 5'd3, 1, 1);
    step_ctl("t2_lw", NORM);
    set_id(1, 5'd3, 5'd3, 1, 5'd4, 1, 0);
`ifdef PIPE_FWD_EN
    step_ctl("t2_stall", STALL);
    step_ctl("t2_add_go", NORM);
    idle_in();
    @(negedge clk);
    check("t2_fwd_ab", 32'({bus.fwd_a, bus.fwd_b}), 32'h5);
    tick();
    check("t2_cnt", 32'(bus.stall_cnt), 32'd1);
`else
    step_ctl("t2_stall1", STALL);
    step_ctl("t2_stall2", STALL);
    step_ctl("t2_add_go", NORM);
    tick();
    check("t2_cnt", 32'(bus.stall_cnt), 32'd2);
`endif

    // 3: add $3 ; beq $1,$2 ; sub $4,$3 arrives as the beq resolves taken
    do_reset();
    set_id(1, 5'd1, 5'd2, 1, 5'd3, 1, 0);
    step_ctl("t3_add", NORM);
    set_id(1, 5'd1, 5'd2, 1, 5'd0, 0, 0);
    step_ctl("t3_beq", NORM);
    set_id(1, 5'd3, 5'd5, 1, 5'd4, 1, 0);
    bus.ex_br_taken = 1'b1;
    step_ctl("t3_branch", BRANCH);
    // The discarded sub must not be in EX: a reader of $4 proceeds.
    bus.ex_br_taken = 1'b0;
    set_id(1, 5'd4, 5'd0, 0, 5'd6, 1, 0);
    step_ctl("t3_after", NORM);
    check("t3_cnt", 32'(bus.stall_cnt), 32'd0);

    // 4: sw acked on the 4th request cycle; branch in EX held until exit
    do_reset();
    bus.mem_access = 1'b1;
    bus.ex_br_taken = 1'b1;
    step_ctl("t4_req", FREEZE);
    step_ctl("t4_wait1", FREEZE);
    step_ctl("t4_wait2", FREEZE);
    bus.dmem_ack = 1'b1;
    step_ctl("t4_ack_branch", 6'b111111);
    idle_in();
    step_ctl("t4_run", NORM);
    check("t4_cnt", 32'(bus.stall_cnt), 32'd3);

    // 5: no ack -> ERR after 15 wait cycles; async reset clears it
    do_reset();
    bus.mem_access = 1'b1;
    step_ctl("t5_req", FREEZE);
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      check("t5_wait", 32'({ctl, bus.err_timeout}), 32'({FREEZE, 1'b0}));
      tick();
    end
    @(negedge clk);
    check("t5_err", 32'({ctl, bus.err_timeout}), 32'({DEAD, 1'b1}));
    tick();
    bus.dmem_ack = 1'b1;
    @(negedge clk);
    check("t5_err_sticky", 32'({ctl, bus.err_timeout}), 32'({DEAD, 1'b1}));
    bus.dmem_ack = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("t5_rst_ctl", 32'(ctl), 32'(NORM));
    check("t5_rst_err", 32'(bus.err_timeout), 32'h0);
    check("t5_rst_cnt", 32'(bus.stall_cnt), 32'h0);
    tick();
    rst_n = 1'b1;

    // 6: write $0 then read $0; then saturate stall_cnt in ERR
    do_reset();
    set_id(1, 5'd1, 5'd2, 1, 5'd0, 1, 0);
    step_ctl("t6_wr0", NORM);
    set_id(1, 5'd0, 5'd0, 1, 5'd5, 1, 0);
    @(negedge clk);
    check("t6_rd0", 32'(ctl), 32'(NORM));
    tick();
    idle_in();
    @(negedge clk);
    check("t6_fwd", 32'({bus.fwd_a, bus.fwd_b}), 32'h0);
    tick();
    check("t6_cnt", 32'(bus.stall_cnt), 32'd0);
    bus.mem_access = 1'b1;
    repeat (65540) @(posedge clk);
    #1;
    check("t6_sat", 32'(bus.stall_cnt), 32'hFFFF);
    tick();
    check("t6_sat_hold", 32'(bus.stall_cnt), 32'hFFFF);
    check("t6_err", 32'({ctl, bus.err_timeout}), 32'({DEAD, 1'b1}));
    do_reset();
    check("t6_clr", 32'({bus.stall_cnt, bus.err_timeout}), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
